// File: rtl/salamander_bus_pkg.sv
// rtl/salamander_bus_pkg.sv - shared types and helpers for the Salamander CPU-port bus driver
package salamander_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_WAIT_VBL = 2'd2,
    OP_SET_FLIP = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    SEL_VZCS   = 3'd0,
    SEL_VCS1   = 3'd1,
    SEL_VCS2   = 3'd2,
    SEL_CHACS  = 3'd3,
    SEL_OBJRAM = 3'd4
  } sel_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_S0       = 4'd1,
    ST_S1       = 4'd2,
    ST_S2       = 4'd3,
    ST_S3       = 4'd4,
    ST_S4       = 4'd5,
    ST_S5       = 4'd6,
    ST_S6       = 4'd7,
    ST_S7       = 4'd8,
    ST_SW       = 4'd9,
    ST_VWAIT_HI = 4'd10,
    ST_VWAIT_LO = 4'd11,
    ST_RESP     = 4'd12
  } bus_state_e;

  localparam int NUM_CS = 5;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel <= 3'(SEL_OBJRAM);
  endfunction

  // One-hot, active-high; bit order matches {OBJRAM,CHACS,VCS2,VCS1,VZCS}.
  function automatic logic [NUM_CS-1:0] sel_to_cs(input logic [2:0] sel);
    logic [NUM_CS-1:0] oh;
    oh = '0;
    case (sel)
      3'(SEL_VZCS):   oh = 5'b00001;
      3'(SEL_VCS1):   oh = 5'b00010;
      3'(SEL_VCS2):   oh = 5'b00100;
      3'(SEL_CHACS):  oh = 5'b01000;
      3'(SEL_OBJRAM): oh = 5'b10000;
      default:        oh = 5'b00000;
    endcase
    return oh;
  endfunction

  function automatic logic [15:0] mask_read(input logic [15:0] din, input logic [1:0] be_n);
    return {be_n[1] ? 8'h00 : din[15:8], be_n[0] ? 8'h00 : din[7:0]};
  endfunction

endpackage

// File: rtl/salamander_cpubus_driver.sv
// rtl/salamander_cpubus_driver.sv - command-driven 68000-style bus initiator for the video board CPU port
module salamander_cpubus_driver
  import salamander_bus_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [19:0] VBL_TIMEOUT = 20'hFFFFF
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_MRST_n,
  input  logic        i_EMU_CLK9MPCEN_n,
  input  logic        i_EMU_CLK9MNCEN_n,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  input  logic [1:0]  i_CMD_OP,
  input  logic [2:0]  i_CMD_SEL,
  input  logic [14:0] i_CMD_ADDR,
  input  logic [15:0] i_CMD_DATA,
  input  logic [1:0]  i_CMD_BE_n,
  output logic        o_RSP_VALID,
  output logic [15:0] o_RSP_DATA,
  output logic        o_RSP_ERR,
  output logic [14:0] o_CPU_ADDR,
  input  logic [15:0] i_CPU_DIN,
  output logic [15:0] o_CPU_DOUT,
  output logic        o_CPU_RW,
  output logic        o_CPU_UDS_n,
  output logic        o_CPU_LDS_n,
  output logic        o_VZCS_n,
  output logic        o_VCS1_n,
  output logic        o_VCS2_n,
  output logic        o_CHACS_n,
  output logic        o_OBJRAM_n,
  output logic        o_HFLIP,
  output logic        o_VFLIP,
  input  logic        i_VBLANK_n
);

  logic pcen;
  logic ncen;
  assign pcen = ~i_EMU_CLK9MPCEN_n;
  assign ncen = ~i_EMU_CLK9MNCEN_n;

  bus_state_e        state;
  op_e               op_q;
  logic [2:0]        sel_q;
  logic [14:0]       addr_q;
  logic [15:0]       data_q;
  logic [1:0]        be_q;
  logic [2:0]        wait_cnt;
  logic [19:0]       vbl_cnt;
  logic [NUM_CS-1:0] cs_n;

  assign o_VZCS_n   = cs_n[0];
  assign o_VCS1_n   = cs_n[1];
  assign o_VCS2_n   = cs_n[2];
  assign o_CHACS_n  = cs_n[3];
  assign o_OBJRAM_n = cs_n[4];

  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_WRITE;
      sel_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= 2'b11;
      wait_cnt    <= '0;
      vbl_cnt     <= '0;
      o_CMD_READY <= 1'b0;
      o_RSP_VALID <= 1'b0;
      o_RSP_DATA  <= 16'h0000;
      o_RSP_ERR   <= 1'b0;
      o_CPU_ADDR  <= '0;
      o_CPU_DOUT  <= 16'hFFFF;
      o_CPU_RW    <= 1'b1;
      o_CPU_UDS_n <= 1'b1;
      o_CPU_LDS_n <= 1'b1;
      cs_n        <= '1;
      o_HFLIP     <= 1'b0;
      o_VFLIP     <= 1'b0;
    end else begin
      o_RSP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!o_CMD_READY) begin
            o_CMD_READY <= 1'b1;
          end else if (i_CMD_VALID) begin
            o_CMD_READY <= 1'b0;
            op_q        <= op_e'(i_CMD_OP);
            sel_q       <= i_CMD_SEL;
            addr_q      <= i_CMD_ADDR;
            data_q      <= i_CMD_DATA;
            be_q        <= i_CMD_BE_n;
            o_RSP_DATA  <= 16'h0000;
            o_RSP_ERR   <= 1'b0;
            case (op_e'(i_CMD_OP))
              OP_WRITE, OP_READ: begin
                // Malformed bus requests are answered without touching the bus.
                if (!sel_legal(i_CMD_SEL) || i_CMD_BE_n == 2'b11) begin
                  state       <= ST_RESP;
                  o_RSP_VALID <= 1'b1;
                  o_RSP_ERR   <= 1'b1;
                end else begin
                  state    <= ST_S0;
                  o_CPU_RW <= (op_e'(i_CMD_OP) == OP_READ);
                end
              end
              OP_WAIT_VBL: begin
                state   <= ST_VWAIT_HI;
                vbl_cnt <= '0;
              end
              default: begin
                state       <= ST_RESP;
                o_RSP_VALID <= 1'b1;
                o_HFLIP     <= i_CMD_DATA[0];
                o_VFLIP     <= i_CMD_DATA[1];
              end
            endcase
          end
        end

        ST_S0: if (pcen) begin
          state      <= ST_S1;
          o_CPU_ADDR <= addr_q;
        end

        ST_S1: if (ncen) begin
          state <= ST_S2;
          cs_n  <= ~sel_to_cs(sel_q);
          if (op_q == OP_READ) begin
            o_CPU_UDS_n <= be_q[1];
            o_CPU_LDS_n <= be_q[0];
          end
        end

        ST_S2: if (pcen) begin
          state <= ST_S3;
          if (op_q == OP_WRITE) o_CPU_DOUT <= data_q;
        end

        ST_S3: if (ncen) begin
          state <= ST_S4;
          if (op_q == OP_WRITE) begin
            o_CPU_UDS_n <= be_q[1];
            o_CPU_LDS_n <= be_q[0];
          end
        end

        ST_S4: if (pcen) begin
          if (WAIT_STATES > 0) begin
            state    <= ST_SW;
            wait_cnt <= '0;
          end else begin
            state <= ST_S5;
          end
        end

        // Each wait state spans one full 9M period (PCEN to PCEN).
        ST_SW: if (pcen) begin
          if (wait_cnt == 3'(WAIT_STATES - 1)) state <= ST_S5;
          else wait_cnt <= wait_cnt + 3'd1;
        end

        ST_S5: if (ncen) state <= ST_S6;

        ST_S6: if (pcen) begin
          state       <= ST_S7;
          cs_n        <= '1;
          o_CPU_UDS_n <= 1'b1;
          o_CPU_LDS_n <= 1'b1;
          if (op_q == OP_READ) o_RSP_DATA <= mask_read(i_CPU_DIN, be_q);
        end

        ST_S7: if (ncen) begin
          state       <= ST_RESP;
          o_RSP_VALID <= 1'b1;
          o_CPU_DOUT  <= 16'hFFFF;
          o_CPU_RW    <= 1'b1;
        end

        ST_VWAIT_HI, ST_VWAIT_LO: begin
          if (state == ST_VWAIT_LO && !i_VBLANK_n) begin
            state       <= ST_RESP;
            o_RSP_VALID <= 1'b1;
          end else if (vbl_cnt == VBL_TIMEOUT) begin
            state       <= ST_RESP;
            o_RSP_VALID <= 1'b1;
            o_RSP_ERR   <= 1'b1;
          end else begin
            vbl_cnt <= vbl_cnt + 20'd1;
            if (state == ST_VWAIT_HI && i_VBLANK_n) state <= ST_VWAIT_LO;
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          o_CMD_READY <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_salamander_cpubus_driver.sv
// tb/tb_salamander_cpubus_driver.sv - directed self-checking bench for salamander_cpubus_driver
module tb_salamander_cpubus_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcen_n = 1'b1;
  logic        ncen_n = 1'b1;
  logic        cmd_valid0 = 1'b0;
  logic        cmd_valid3 = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_sel = 3'd0;
  logic [14:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [1:0]  cmd_be_n = 2'b00;
  logic [15:0] cpu_din = 16'h1234;
  logic        vblank_n = 1'b1;

  logic        ready0, rsp_valid0, rsp_err0, rw0, uds0, lds0;
  logic        vzcs0, vcs1_0, vcs2_0, chacs0, objram0, hflip0, vflip0;
  logic [15:0] rsp_data0, dout0;
  logic [14:0] addr0;
  logic        ready3, rsp_valid3, rsp_err3, rw3, uds3, lds3;
  logic        vzcs3, vcs1_3, vcs2_3, chacs3, objram3, hflip3, vflip3;
  logic [15:0] rsp_data3, dout3;
  logic [14:0] addr3;

  int checks = 0;
  int errors = 0;

  salamander_cpubus_driver #(.WAIT_STATES(0), .VBL_TIMEOUT(20'd100)) dut0 (
    .i_EMU_MCLK(clk), .i_MRST_n(rst_n),
    .i_EMU_CLK9MPCEN_n(pcen_n), .i_EMU_CLK9MNCEN_n(ncen_n),
    .i_CMD_VALID(cmd_valid0), .o_CMD_READY(ready0),
    .i_CMD_OP(cmd_op), .i_CMD_SEL(cmd_sel), .i_CMD_ADDR(cmd_addr),
    .i_CMD_DATA(cmd_data), .i_CMD_BE_n(cmd_be_n),
    .o_RSP_VALID(rsp_valid0), .o_RSP_DATA(rsp_data0), .o_RSP_ERR(rsp_err0),
    .o_CPU_ADDR(addr0), .i_CPU_DIN(cpu_din), .o_CPU_DOUT(dout0), .o_CPU_RW(rw0),
    .o_CPU_UDS_n(uds0), .o_CPU_LDS_n(lds0),
    .o_VZCS_n(vzcs0), .o_VCS1_n(vcs1_0), .o_VCS2_n(vcs2_0), .o_CHACS_n(chacs0),
    .o_OBJRAM_n(objram0), .o_HFLIP(hflip0), .o_VFLIP(vflip0), .i_VBLANK_n(vblank_n)
  );

  salamander_cpubus_driver #(.WAIT_STATES(3), .VBL_TIMEOUT(20'd100)) dut3 (
    .i_EMU_MCLK(clk), .i_MRST_n(rst_n),
    .i_EMU_CLK9MPCEN_n(pcen_n), .i_EMU_CLK9MNCEN_n(ncen_n),
    .i_CMD_VALID(cmd_valid3), .o_CMD_READY(ready3),
    .i_CMD_OP(cmd_op), .i_CMD_SEL(cmd_sel), .i_CMD_ADDR(cmd_addr),
    .i_CMD_DATA(cmd_data), .i_CMD_BE_n(cmd_be_n),
    .o_RSP_VALID(rsp_valid3), .o_RSP_DATA(rsp_data3), .o_RSP_ERR(rsp_err3),
    .o_CPU_ADDR(addr3), .i_CPU_DIN(cpu_din), .o_CPU_DOUT(dout3), .o_CPU_RW(rw3),
    .o_CPU_UDS_n(uds3), .o_CPU_LDS_n(lds3),
    .o_VZCS_n(vzcs3), .o_VCS1_n(vcs1_3), .o_VCS2_n(vcs2_3), .o_CHACS_n(chacs3),
    .o_OBJRAM_n(objram3), .o_HFLIP(hflip3), .o_VFLIP(vflip3), .i_VBLANK_n(vblank_n)
  );

  initial forever #5 clk = ~clk;

  // 9M enables: one MCLK-wide PCEN then NCEN, each every 4 MCLK
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      pcen_n = (phase != 0);
      ncen_n = (phase != 2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Results of the most recent do_cmd on dut0
  logic        m_got, m_err, m_rw_low, m_uds_low, m_lds_low, m_any_cs, m_multi, m_wrong_cs;
  logic        m_clean, m_pulse_after, m_ready_after;
  logic [15:0] m_data, m_dout_stb;
  logic [14:0] m_addr_stb;
  int          m_cyc, m_n, m_cs_first, m_cs_last, m_stb_first;

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [14:0] addr,
                        input logic [15:0] data, input logic [1:0] be, input int budget);
    logic [4:0] cs, lowb, tgt;
    logic started;
    int b, n;
    m_got = 0; m_err = 0; m_rw_low = 0; m_uds_low = 0; m_lds_low = 0; m_any_cs = 0;
    m_multi = 0; m_wrong_cs = 0; m_clean = 0; m_data = '0; m_dout_stb = '0; m_addr_stb = '0;
    m_cyc = -1; m_n = -1; m_cs_first = -1; m_cs_last = -1; m_stb_first = -1;
    tgt = (sel < 3'd5) ? (5'b00001 << sel) : 5'b00000;
    b = 0;
    while (!ready0 && b < 20) begin @(posedge clk); #1; b++; end
    cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_data = data; cmd_be_n = be;
    cmd_valid0 = 1'b1;
    @(posedge clk); #1;
    cmd_valid0 = 1'b0;
    started = 0; n = 0;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) begin
        @(posedge clk);
        if (!started && !pcen_n) started = 1;
        if (started && (!pcen_n || !ncen_n)) n++;
        #1;
      end
      cs = {objram0, chacs0, vcs2_0, vcs1_0, vzcs0};
      lowb = ~cs;
      if (lowb != 5'b0) m_any_cs = 1;
      if ($countones(lowb) > 1) m_multi = 1;
      if ((lowb & ~tgt) != 5'b0) m_wrong_cs = 1;
      if ((lowb & tgt) != 5'b0) begin
        if (m_cs_first < 0) m_cs_first = n;
        m_cs_last = n;
      end
      if (!uds0 || !lds0) begin
        if (m_stb_first < 0) begin m_stb_first = n; m_dout_stb = dout0; m_addr_stb = addr0; end
      end
      if (!uds0) m_uds_low = 1;
      if (!lds0) m_lds_low = 1;
      if (!rw0) m_rw_low = 1;
      if (rsp_valid0) begin
        m_got = 1; m_cyc = k; m_n = n; m_data = rsp_data0; m_err = rsp_err0;
        m_clean = (cs == 5'h1f) && uds0 && lds0;
        break;
      end
    end
    @(posedge clk); #1;
    m_pulse_after = rsp_valid0;
    m_ready_after = ready0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({addr0, dout0, rw0, uds0, lds0} !== {15'h0, 16'hFFFF, 3'b111}) begin
      errors++; $display("FAIL reset_bus: got addr=%h dout=%h rw/uds/lds=%b%b%b expected 0000 ffff 111", addr0, dout0, rw0, uds0, lds0); end
    checks++; if ({objram0, chacs0, vcs2_0, vcs1_0, vzcs0} !== 5'h1f) begin
      errors++; $display("FAIL reset_cs: got %b expected 11111", {objram0, chacs0, vcs2_0, vcs1_0, vzcs0}); end
    checks++; if ({ready0, rsp_valid0, rsp_err0, hflip0, vflip0, rsp_data0} !== 21'h0) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b vld=%b err=%b h=%b v=%b data=%h expected all 0", ready0, rsp_valid0, rsp_err0, hflip0, vflip0, rsp_data0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready0); end
  endtask

  task automatic test_write();
    do_cmd(2'd0, 3'd3, 15'h0123, 16'hBEEF, 2'b00, 100);
    checks++; if (m_got !== 1'b1 || m_n != 8) begin
      errors++; $display("FAIL write_rsp: got rsp=%b enables=%0d expected 1 8", m_got, m_n); end
    checks++; if (m_cs_first != 2 || m_cs_last != 6) begin
      errors++; $display("FAIL write_cs_window: got %0d..%0d expected 2..6", m_cs_first, m_cs_last); end
    checks++; if (m_stb_first != 4) begin
      errors++; $display("FAIL write_strobe_start: got %0d expected 4", m_stb_first); end
    checks++; if (m_dout_stb !== 16'hBEEF || m_addr_stb !== 15'h0123) begin
      errors++; $display("FAIL write_bus_at_strobe: got dout=%h addr=%h expected beef 0123", m_dout_stb, m_addr_stb); end
    checks++; if (m_rw_low !== 1'b1 || m_err !== 1'b0 || m_data !== 16'h0) begin
      errors++; $display("FAIL write_rw_err: got rwlow=%b err=%b data=%h expected 1 0 0000", m_rw_low, m_err, m_data); end
    checks++; if (m_wrong_cs !== 1'b0 || m_multi !== 1'b0 || m_clean !== 1'b1) begin
      errors++; $display("FAIL write_cs_rules: got wrong=%b multi=%b clean=%b expected 0 0 1", m_wrong_cs, m_multi, m_clean); end
    checks++; if (m_pulse_after !== 1'b0 || m_ready_after !== 1'b1) begin
      errors++; $display("FAIL write_pulse: got vld_after=%b rdy_after=%b expected 0 1", m_pulse_after, m_ready_after); end
    checks++; if (dout0 !== 16'hFFFF || rw0 !== 1'b1) begin
      errors++; $display("FAIL write_idle_bus: got dout=%h rw=%b expected ffff 1", dout0, rw0); end
  endtask

  task automatic test_read();
    do_cmd(2'd1, 3'd4, 15'h7FFF, 16'h0000, 2'b10, 100);
    checks++; if (m_got !== 1'b1 || m_n != 8 || m_err !== 1'b0) begin
      errors++; $display("FAIL read_rsp: got rsp=%b enables=%0d err=%b expected 1 8 0", m_got, m_n, m_err); end
    checks++; if (m_data !== 16'h0034) begin
      errors++; $display("FAIL read_data: got %h expected 0034", m_data); end
    checks++; if (m_rw_low !== 1'b0 || m_uds_low !== 1'b0 || m_lds_low !== 1'b1) begin
      errors++; $display("FAIL read_strobes: got rwlow=%b udslow=%b ldslow=%b expected 0 0 1", m_rw_low, m_uds_low, m_lds_low); end
    checks++; if (m_cs_first != 2 || m_wrong_cs !== 1'b0) begin
      errors++; $display("FAIL read_cs: got first=%0d wrong=%b expected 2 0", m_cs_first, m_wrong_cs); end
  endtask

  task automatic test_illegal();
    do_cmd(2'd0, 3'd6, 15'h0001, 16'h5555, 2'b00, 20);
    checks++; if (m_got !== 1'b1 || m_cyc > 2 || m_err !== 1'b1) begin
      errors++; $display("FAIL illegal_sel: got rsp=%b cyc=%0d err=%b expected 1 <=2 1", m_got, m_cyc, m_err); end
    checks++; if (m_any_cs !== 1'b0 || m_uds_low !== 1'b0 || m_lds_low !== 1'b0) begin
      errors++; $display("FAIL illegal_sel_bus: got cs=%b uds=%b lds=%b expected 0 0 0", m_any_cs, m_uds_low, m_lds_low); end
    do_cmd(2'd1, 3'd3, 15'h0002, 16'h0000, 2'b11, 20);
    checks++; if (m_got !== 1'b1 || m_cyc > 2 || m_err !== 1'b1) begin
      errors++; $display("FAIL illegal_be: got rsp=%b cyc=%0d err=%b expected 1 <=2 1", m_got, m_cyc, m_err); end
    checks++; if (m_any_cs !== 1'b0 || m_uds_low !== 1'b0 || m_lds_low !== 1'b0 || m_rw_low !== 1'b0) begin
      errors++; $display("FAIL illegal_be_bus: got cs=%b uds=%b lds=%b rwlow=%b expected 0 0 0 0", m_any_cs, m_uds_low, m_lds_low, m_rw_low); end
  endtask

  task automatic test_flip();
    do_cmd(2'd3, 3'd0, 15'h0, 16'h0002, 2'b00, 20);
    checks++; if (vflip0 !== 1'b1 || hflip0 !== 1'b0 || m_err !== 1'b0 || m_cyc > 2) begin
      errors++; $display("FAIL flip_10: got v=%b h=%b err=%b cyc=%0d expected 1 0 0 <=2", vflip0, hflip0, m_err, m_cyc); end
    checks++; if (m_any_cs !== 1'b0 || m_uds_low !== 1'b0 || m_lds_low !== 1'b0) begin
      errors++; $display("FAIL flip_bus: got cs=%b uds=%b lds=%b expected 0 0 0", m_any_cs, m_uds_low, m_lds_low); end
    do_cmd(2'd3, 3'd0, 15'h0, 16'h0001, 2'b00, 20);
    do_cmd(2'd0, 3'd0, 15'h0040, 16'h1111, 2'b00, 100);
    checks++; if (vflip0 !== 1'b0 || hflip0 !== 1'b1) begin
      errors++; $display("FAIL flip_persist: got v=%b h=%b expected 0 1", vflip0, hflip0); end
  endtask

  task automatic test_wait_vbl();
    vblank_n = 1'b0;
    fork
      do_cmd(2'd2, 3'd0, 15'h0, 16'h0, 2'b00, 200);
      begin
        @(posedge clk);
        repeat (10) @(negedge clk);
        vblank_n = 1'b1;
        repeat (20) @(negedge clk);
        vblank_n = 1'b0;
      end
    join
    checks++; if (m_got !== 1'b1 || m_cyc != 31 || m_err !== 1'b0) begin
      errors++; $display("FAIL vbl_next_blank: got rsp=%b cyc=%0d err=%b expected 1 31 0", m_got, m_cyc, m_err); end
    vblank_n = 1'b1;
    do_cmd(2'd2, 3'd0, 15'h0, 16'h0, 2'b00, 200);
    checks++; if (m_got !== 1'b1 || m_cyc != 102 || m_err !== 1'b1) begin
      errors++; $display("FAIL vbl_timeout: got rsp=%b mclk=%0d err=%b expected 1 101 1", m_got, m_cyc - 1, m_err); end
  endtask

  task automatic test_back_to_back();
    int pulses, bad;
    pulses = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_cmd(2'd0, 3'(i % 5), 15'(15'h0100 + 15'(i)), 16'(16'hA000 + 16'(i)), 2'b00, 60);
      if (m_got) pulses++;
      if (!m_got || m_n != 8 || m_err || m_addr_stb !== 15'(15'h0100 + 15'(i)) ||
          m_dout_stb !== 16'(16'hA000 + 16'(i)) || m_wrong_cs || m_cs_first != 2) bad++;
    end
    checks++; if (pulses != 16) begin
      errors++; $display("FAIL b2b_pulses: got %0d expected 16", pulses); end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL b2b_cycles: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic run_dut3_until(input int stop_n, output int n_out, output logic got);
    logic started;
    int n;
    int b;
    b = 0;
    while (!ready3 && b < 20) begin @(posedge clk); #1; b++; end
    cmd_op = 2'd0; cmd_sel = 3'd1; cmd_addr = 15'h0055; cmd_data = 16'hA5A5; cmd_be_n = 2'b00;
    cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    started = 0; n = 0; got = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (!started && !pcen_n) started = 1;
      if (started && (!pcen_n || !ncen_n)) n++;
      #1;
      if (rsp_valid3) begin got = 1; break; end
      if (n == stop_n) break;
    end
    n_out = n;
  endtask

  task automatic test_wait_states();
    int n;
    logic got;
    run_dut3_until(-1, n, got);
    checks++; if (got !== 1'b1 || n != 14 || rsp_err3 !== 1'b0) begin
      errors++; $display("FAIL ws3_length: got rsp=%b enables=%0d err=%b expected 1 14 0", got, n, rsp_err3); end
    @(posedge clk); #1;
    run_dut3_until(11, n, got);
    checks++; if (got !== 1'b0 || vcs1_3 !== 1'b0 || uds3 !== 1'b0 || lds3 !== 1'b0) begin
      errors++; $display("FAIL ws3_in_s5: got rsp=%b cs=%b uds=%b lds=%b expected 0 0 0 0", got, vcs1_3, uds3, lds3); end
    rst_n = 1'b0;
    #1;
    checks++; if ({objram3, chacs3, vcs2_3, vcs1_3, vzcs3, uds3, lds3} !== 7'h7f || rsp_valid3 !== 1'b0) begin
      errors++; $display("FAIL ws3_reset_async: got cs/stb=%b vld=%b expected 1111111 0", {objram3, chacs3, vcs2_3, vcs1_3, vzcs3, uds3, lds3}, rsp_valid3); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready3 !== 1'b1 || rsp_valid3 !== 1'b0) begin
      errors++; $display("FAIL ws3_ready_after_reset: got rdy=%b vld=%b expected 1 0", ready3, rsp_valid3); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_flip();
    test_wait_vbl();
    test_back_to_back();
    test_wait_states();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
